// File: rtl/ahb_lite_pkg.sv
// Shared AHB-Lite encodings and the initiator's state type.
package ahb_lite_pkg;

    localparam logic [1:0] HTRANS_IDLE     = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ   = 2'b10;

    localparam logic [2:0] HSIZE_WORD      = 3'b010;
    localparam logic [2:0] HBURST_SINGLE   = 3'b000;
    localparam logic [3:0] HPROT_DATA_PRIV = 4'b0011;

    localparam logic [1:0] HRESP_OKAY      = 2'b00;
    localparam logic [1:0] HRESP_ERROR     = 2'b01;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        ADDR = 2'b01,
        DATA = 2'b10,
        RESP = 2'b11
    } state_t;

endpackage

// File: rtl/ahb_lite_single_master.sv
// Single-outstanding AHB-Lite initiator: one valid/ready command becomes one
// word-sized SINGLE transfer, answered by a one-cycle response pulse.
module ahb_lite_single_master
    import ahb_lite_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 256,
    parameter int unsigned TO_W        = 9
) (
    input  logic        I_ahb_clk,
    input  logic        I_rst,
    input  logic        I_cmd_valid,
    output logic        O_cmd_ready,
    input  logic        I_cmd_write,
    input  logic [31:0] I_cmd_addr,
    input  logic [31:0] I_cmd_wdata,
    output logic        O_rsp_valid,
    output logic [31:0] O_rsp_rdata,
    output logic        O_rsp_err,
    output logic        O_rsp_timeout,
    output logic [1:0]  O_ahb_htrans,
    output logic        O_ahb_hwrite,
    output logic [31:0] O_ahb_haddr,
    output logic [2:0]  O_ahb_hsize,
    output logic [2:0]  O_ahb_hburst,
    output logic [3:0]  O_ahb_hprot,
    output logic        O_ahb_hmastlock,
    output logic [31:0] O_ahb_hwdata,
    input  logic [31:0] I_ahb_hrdata,
    input  logic [1:0]  I_ahb_hresp,
    input  logic        I_ahb_hready
);

    localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT_CYC);

    state_t      state_q, state_d;
    logic [TO_W-1:0] cnt_q, cnt_d;
    logic [31:0] wdata_q, wdata_d;
    logic [1:0]  htrans_q, htrans_d;
    logic        hwrite_q, hwrite_d;
    logic [31:0] haddr_q, haddr_d;
    logic [31:0] hwdata_q, hwdata_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        rsp_err_q, rsp_err_d;
    logic        rsp_timeout_q, rsp_timeout_d;
    logic        timed_out;
    logic [TO_W-1:0] cnt_inc;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        wdata_d       = wdata_q;
        htrans_d      = htrans_q;
        hwrite_d      = hwrite_q;
        haddr_d       = haddr_q;
        hwdata_d      = hwdata_q;
        rsp_valid_d   = 1'b0;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_err_d     = rsp_err_q;
        rsp_timeout_d = rsp_timeout_q;
        timed_out     = (cnt_q == TO_LIMIT);
        cnt_inc       = timed_out ? cnt_q : cnt_q + TO_W'(1);

        case (state_q)
            IDLE: begin
                if (I_cmd_valid) begin
                    wdata_d = I_cmd_wdata;
                    cnt_d   = '0;
                    // Misaligned commands never reach the bus.
                    if (I_cmd_addr[1:0] != 2'b00) begin
                        state_d       = RESP;
                        rsp_valid_d   = 1'b1;
                        rsp_err_d     = 1'b1;
                        rsp_timeout_d = 1'b0;
                    end else begin
                        state_d  = ADDR;
                        htrans_d = HTRANS_NONSEQ;
                        haddr_d  = I_cmd_addr;
                        hwrite_d = I_cmd_write;
                    end
                end
            end
            ADDR: begin
                cnt_d = cnt_inc;
                if (I_ahb_hready) begin
                    state_d  = DATA;
                    htrans_d = HTRANS_IDLE;
                    hwdata_d = hwrite_q ? wdata_q : 32'h0;
                end else if (timed_out) begin
                    state_d       = RESP;
                    htrans_d      = HTRANS_IDLE;
                    rsp_valid_d   = 1'b1;
                    rsp_err_d     = 1'b1;
                    rsp_timeout_d = 1'b1;
                end
            end
            DATA: begin
                cnt_d = cnt_inc;
                // Completion takes priority over a watchdog expiring on the same edge.
                if (I_ahb_hready) begin
                    state_d       = RESP;
                    rsp_valid_d   = 1'b1;
                    rsp_err_d     = (I_ahb_hresp == HRESP_ERROR);
                    rsp_timeout_d = 1'b0;
                    if (!hwrite_q && (I_ahb_hresp != HRESP_ERROR)) begin
                        rsp_rdata_d = I_ahb_hrdata;
                    end
                end else if (timed_out) begin
                    state_d       = RESP;
                    rsp_valid_d   = 1'b1;
                    rsp_err_d     = 1'b1;
                    rsp_timeout_d = 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge I_ahb_clk) begin
        if (I_rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            htrans_q      <= HTRANS_IDLE;
            hwrite_q      <= 1'b0;
            haddr_q       <= 32'h0;
            hwdata_q      <= 32'h0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= 32'h0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            htrans_q      <= htrans_d;
            hwrite_q      <= hwrite_d;
            haddr_q       <= haddr_d;
            hwdata_q      <= hwdata_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_err_q     <= rsp_err_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    always_ff @(posedge I_ahb_clk) begin
        wdata_q <= wdata_d;
    end

    assign O_cmd_ready     = (state_q == IDLE);
    assign O_rsp_valid     = rsp_valid_q;
    assign O_rsp_rdata     = rsp_rdata_q;
    assign O_rsp_err       = rsp_err_q;
    assign O_rsp_timeout   = rsp_timeout_q;
    assign O_ahb_htrans    = htrans_q;
    assign O_ahb_hwrite    = hwrite_q;
    assign O_ahb_haddr     = haddr_q;
    assign O_ahb_hwdata    = hwdata_q;
    assign O_ahb_hsize     = HSIZE_WORD;
    assign O_ahb_hburst    = HBURST_SINGLE;
    assign O_ahb_hprot     = HPROT_DATA_PRIV;
    assign O_ahb_hmastlock = 1'b0;

endmodule

// File: tb/tb_ahb_lite_single_master.sv
// Bench for ahb_lite_single_master: behavioural AHB slave plus a response scoreboard.
module tb_ahb_lite_single_master;
    import ahb_lite_pkg::*;

    localparam int TO_CYC = 16;

    // lat = edges after the accepting edge on which rsp_valid was registered high
    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
        logic        tmo;
        logic [7:0]  lat;
    } rsp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_write = 1'b0;
    logic [31:0] cmd_addr  = 32'h0;
    logic [31:0] cmd_wdata = 32'h0;
    logic        cmd_ready, rsp_valid, rsp_err, rsp_timeout, hwrite, hmastlock, hready;
    logic [31:0] rsp_rdata, haddr, hwdata, hrdata;
    logic [1:0]  htrans, hresp;
    logic [2:0]  hsize, hburst;
    logic [3:0]  hprot;

    always #5 clk = ~clk;

    ahb_lite_single_master #(.TIMEOUT_CYC(TO_CYC), .TO_W(5)) dut (
        .I_ahb_clk      (clk),
        .I_rst          (rst),
        .I_cmd_valid    (cmd_valid),
        .O_cmd_ready    (cmd_ready),
        .I_cmd_write    (cmd_write),
        .I_cmd_addr     (cmd_addr),
        .I_cmd_wdata    (cmd_wdata),
        .O_rsp_valid    (rsp_valid),
        .O_rsp_rdata    (rsp_rdata),
        .O_rsp_err      (rsp_err),
        .O_rsp_timeout  (rsp_timeout),
        .O_ahb_htrans   (htrans),
        .O_ahb_hwrite   (hwrite),
        .O_ahb_haddr    (haddr),
        .O_ahb_hsize    (hsize),
        .O_ahb_hburst   (hburst),
        .O_ahb_hprot    (hprot),
        .O_ahb_hmastlock(hmastlock),
        .O_ahb_hwdata   (hwdata),
        .I_ahb_hrdata   (hrdata),
        .I_ahb_hresp    (hresp),
        .I_ahb_hready   (hready)
    );

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   nonseq_cnt = 0;
    rsp_t sb[$];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (htrans == HTRANS_NONSEQ) nonseq_cnt <= nonseq_cnt + 1;
    end

    // Slave model: cfg_wait wait states per data phase, two-cycle ERROR, or stuck-low hready.
    int          cfg_wait = 0;
    bit          cfg_err = 1'b0;
    bit          cfg_stuck = 1'b0;
    logic        s_act, s_wr;
    logic [3:0]  s_idx;
    int          s_wait;
    logic [31:0] mem [16];

    always @(posedge clk) begin
        if (rst) begin
            s_act  <= 1'b0;
            s_wr   <= 1'b0;
            s_idx  <= 4'h0;
            s_wait <= 0;
            for (int i = 0; i < 16; i++) mem[i] <= (i == 1) ? 32'h0000_0ABC : 32'h0;
        end else begin
            if (s_act && hready) begin
                s_act <= 1'b0;
                if (s_wr && !cfg_err) mem[s_idx] <= hwdata;
            end else if (s_act) begin
                s_wait <= s_wait - 1;
            end
            if (htrans == HTRANS_NONSEQ && hready) begin
                s_act  <= 1'b1;
                s_wr   <= hwrite;
                s_idx  <= haddr[5:2];
                s_wait <= cfg_err ? 1 : cfg_wait;
            end
        end
    end

    always_comb begin
        hready = 1'b1;
        hresp  = HRESP_OKAY;
        hrdata = 32'h0;
        if (cfg_stuck) begin
            hready = 1'b0;
        end else if (s_act) begin
            hready = (s_wait == 0);
            if (cfg_err) hresp = HRESP_ERROR;
            if (!s_wr) hrdata = cfg_err ? 32'hBAD0_BAD0 : mem[s_idx];
        end
    end

    task automatic run_cmd(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                           output rsp_t o, output int acc, output logic px,
                           output logic [1:0] ht_after, output logic hw_held);
        int seen;
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wd;
        acc = -1; seen = 0; o = '0; o.lat = 8'hFF;
        px = 1'b0; ht_after = htrans; hw_held = 1'b1;
        for (int i = 0; i < 64 && acc < 0; i++) begin
            if (cmd_ready) acc = cyc + 1;
            @(posedge clk); #1;
        end
        cmd_valid = 1'b0;
        for (int i = 0; i < 64 && seen == 0 && acc >= 0; i++) begin
            if (rsp_valid) begin
                seen = 1;
                o.rdata = rsp_rdata; o.err = rsp_err; o.tmo = rsp_timeout;
                o.lat = 8'(cyc - acc);
            end else begin
                if (s_act && s_wr && hwdata !== wd) hw_held = 1'b0;
                @(posedge clk); #1;
            end
        end
        checks++;
        if (seen == 0) begin
            errors++;
            $display("FAIL rsp_bound: no response, accept cycle %0d, required a response within 64 cycles", acc);
        end else begin
            @(posedge clk); #1;
            px = rsp_valid;
            ht_after = htrans;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1; rst = 1'b0;
        checks++;
        if ({htrans, hwrite, haddr, hwdata} !== 67'd0) begin
            errors++; $display("FAIL reset_bus got %h required 0", {htrans, hwrite, haddr, hwdata});
        end
        checks++;
        if ({rsp_valid, rsp_rdata, rsp_err, rsp_timeout} !== 35'd0) begin
            errors++; $display("FAIL reset_rsp got %h required 0", {rsp_valid, rsp_rdata, rsp_err, rsp_timeout});
        end
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++; $display("FAIL reset_ready got %b required 1", cmd_ready);
        end
        checks++;
        if ({hsize, hburst, hprot, hmastlock} !== {3'b010, 3'b000, 4'b0011, 1'b0}) begin
            errors++; $display("FAIL const_ctrl got %b required 01000000110", {hsize, hburst, hprot, hmastlock});
        end
    endtask

    task automatic test_zero_wait_read();
        rsp_t o, e; int acc, n0; logic px, hw; logic [1:0] ht;
        cfg_wait = 0; n0 = nonseq_cnt;
        sb.push_back({32'h0000_0ABC, 1'b0, 1'b0, 8'd2});
        run_cmd(1'b0, 32'h0000_0004, 32'h0, o, acc, px, ht, hw);
        e = sb.pop_front();
        checks++;
        if (o !== e) begin errors++; $display("FAIL zw_read got %p required %p", o, e); end
        checks++;
        if (nonseq_cnt - n0 != 1) begin
            errors++; $display("FAIL zw_nonseq got %0d cycles required 1", nonseq_cnt - n0);
        end
        checks++;
        if (px !== 1'b0) begin errors++; $display("FAIL zw_pulse got rsp_valid=%b after pulse required 0", px); end
    endtask

    task automatic test_wait_write();
        rsp_t o, e; int acc; logic px, hw; logic [1:0] ht;
        cfg_wait = 2;
        sb.push_back({32'h0000_0ABC, 1'b0, 1'b0, 8'd4});
        run_cmd(1'b1, 32'h0000_0000, 32'h0000_0001, o, acc, px, ht, hw);
        e = sb.pop_front();
        checks++;
        if (o !== e) begin errors++; $display("FAIL ws_write got %p required %p", o, e); end
        checks++;
        if (hw !== 1'b1) begin errors++; $display("FAIL ws_hwdata got held=%b required 1", hw); end
        checks++;
        if (mem[0] !== 32'h1) begin errors++; $display("FAIL ws_slave_reg got %h required 00000001", mem[0]); end
        cfg_wait = 0;
    endtask

    task automatic test_error_resp();
        rsp_t o, e; int acc; logic px, hw; logic [1:0] ht;
        cfg_err = 1'b1;
        sb.push_back({32'h0000_0ABC, 1'b1, 1'b0, 8'd3});
        run_cmd(1'b0, 32'h0000_0008, 32'h0, o, acc, px, ht, hw);
        e = sb.pop_front();
        checks++;
        if (o !== e) begin errors++; $display("FAIL err_resp got %p required %p", o, e); end
        cfg_err = 1'b0;
        sb.push_back({32'h0000_0001, 1'b0, 1'b0, 8'd2});
        run_cmd(1'b0, 32'h0000_0000, 32'h0, o, acc, px, ht, hw);
        e = sb.pop_front();
        checks++;
        if (o !== e) begin errors++; $display("FAIL err_next got %p required %p", o, e); end
    endtask

    task automatic test_timeout();
        rsp_t o, e; int acc; logic px, hw; logic [1:0] ht;
        cfg_stuck = 1'b1;
        sb.push_back({32'h0000_0001, 1'b1, 1'b1, 8'(TO_CYC + 1)});
        run_cmd(1'b0, 32'h0000_0004, 32'h0, o, acc, px, ht, hw);
        e = sb.pop_front();
        checks++;
        if (o !== e) begin errors++; $display("FAIL timeout_rsp got %p required %p", o, e); end
        checks++;
        if (ht !== HTRANS_IDLE) begin errors++; $display("FAIL timeout_htrans got %b required 00", ht); end
        cfg_stuck = 1'b0;
    endtask

    task automatic test_misaligned();
        rsp_t o, e; int acc, n0; logic px, hw; logic [1:0] ht;
        n0 = nonseq_cnt;
        // Response registered on the accepting edge itself.
        sb.push_back({32'h0000_0001, 1'b1, 1'b0, 8'd0});
        run_cmd(1'b0, 32'h0000_0006, 32'h0, o, acc, px, ht, hw);
        e = sb.pop_front();
        checks++;
        if (o !== e) begin errors++; $display("FAIL misalign_rsp got %p required %p", o, e); end
        checks++;
        if (nonseq_cnt != n0) begin
            errors++; $display("FAIL misalign_bus got %0d NONSEQ cycles required 0", nonseq_cnt - n0);
        end
        checks++;
        if (px !== 1'b0) begin errors++; $display("FAIL misalign_pulse got rsp_valid=%b after pulse required 0", px); end
    endtask

    task automatic test_reset_mid();
        rsp_t o, e; int acc, seen; logic px, hw; logic [1:0] ht; bit in_data;
        cfg_wait = 3;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h4; cmd_wdata = 32'h0;
        acc = -1;
        for (int i = 0; i < 16 && acc < 0; i++) begin
            if (cmd_ready) acc = cyc + 1;
            @(posedge clk); #1;
        end
        cmd_valid = 1'b0;
        in_data = 1'b0;
        for (int i = 0; i < 16 && !in_data; i++) begin
            if (s_act) in_data = 1'b1;
            else begin @(posedge clk); #1; end
        end
        checks++;
        if (!in_data) begin errors++; $display("FAIL rstmid_data got no data phase required one within 16 cycles"); end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if ({htrans, cmd_ready, rsp_valid} !== 4'b0010) begin
            errors++; $display("FAIL rstmid_state got htrans/ready/rsp=%b required 0010", {htrans, cmd_ready, rsp_valid});
        end
        seen = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (rsp_valid) seen = 1;
        end
        checks++;
        if (seen != 0) begin errors++; $display("FAIL rstmid_norsp got rsp_valid pulse required none"); end
        cfg_wait = 0;
        sb.push_back({32'h0000_0ABC, 1'b0, 1'b0, 8'd2});
        run_cmd(1'b0, 32'h0000_0004, 32'h0, o, acc, px, ht, hw);
        e = sb.pop_front();
        checks++;
        if (o !== e) begin errors++; $display("FAIL rstmid_next got %p required %p", o, e); end
    endtask

    task automatic test_back_to_back();
        rsp_t o, e; int acc1, acc2; logic px, hw; logic [1:0] ht;
        cfg_wait = 0;
        sb.push_back({32'h0000_0ABC, 1'b0, 1'b0, 8'd2});
        sb.push_back({32'h0000_0055, 1'b0, 1'b0, 8'd2});
        run_cmd(1'b1, 32'h0000_0010, 32'h0000_0055, o, acc1, px, ht, hw);
        e = sb.pop_front();
        checks++;
        if (o !== e) begin errors++; $display("FAIL b2b_write got %p required %p", o, e); end
        run_cmd(1'b0, 32'h0000_0010, 32'h0, o, acc2, px, ht, hw);
        e = sb.pop_front();
        checks++;
        if (o !== e) begin errors++; $display("FAIL b2b_read got %p required %p", o, e); end
        checks++;
        if (acc2 - acc1 != 4) begin errors++; $display("FAIL b2b_spacing got %0d cycles required 4", acc2 - acc1); end
    endtask

    initial begin
        test_reset();
        test_zero_wait_read();
        test_wait_write();
        test_error_resp();
        test_timeout();
        test_misaligned();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within 200000 time units");
        $fatal(1);
    end

endmodule
